// File: rtl/controle_busca.sv
// ---------------------------------------------------------------------------
// controle_busca: instruction-fetch controller.
//
// Owns the program counter, addresses the combinational instruction memory
// (memoria_instrucoes) and captures each fetched word, together with the
// address it came from, into a small circular prefetch FIFO. The FIFO head
// is offered to the decoder over a valid/ready handshake. A branch redirect
// flushes the FIFO and reloads the PC; a halt request stops new fetches
// while the FIFO keeps draining.
//
// Parameters:
//   PROF_FILA   prefetch FIFO depth in entries (2, 4 or 8)
//   PC_INICIAL  PC value loaded on reset
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   mem_endereco   out  [7:0] instruction memory address (the PC register)
//   mem_instrucao  in   [7:0] instruction word, combinational from mem_endereco
//   desvio_valido  in   redirect request
//   desvio_alvo    in   [7:0] redirect target address
//   parar          in   halt: no new fetches while high
//   instr_valida   out  FIFO head is valid
//   instr          out  [7:0] FIFO head instruction
//   instr_pc       out  [7:0] address the FIFO head was fetched from
//   instr_pronto   in   decoder accepts the head
//   ocupacao       out  [3:0] number of FIFO entries, 0..PROF_FILA
//   num_buscas     out  [15:0] saturating fetch count (only with the
//                       CONTADOR_BUSCAS_EN macro defined)
//
// Optional feature macro: CONTADOR_BUSCAS_EN
// ---------------------------------------------------------------------------
module controle_busca #(
    parameter int unsigned PROF_FILA  = 2,
    parameter logic [7:0]  PC_INICIAL = 8'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [7:0]  mem_endereco,
    input  logic [7:0]  mem_instrucao,
    input  logic        desvio_valido,
    input  logic [7:0]  desvio_alvo,
    input  logic        parar,
    output logic        instr_valida,
    output logic [7:0]  instr,
    output logic [7:0]  instr_pc,
    input  logic        instr_pronto,
    output logic [3:0]  ocupacao
`ifdef CONTADOR_BUSCAS_EN
    ,
    output logic [15:0] num_buscas
`endif
);

    localparam int unsigned PtrW     = $clog2(PROF_FILA);
    localparam logic [3:0]  ProfFila = 4'(PROF_FILA);

    // Program counter
    logic [7:0] pc_q, pc_d;

    // Circular buffer state
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]      cont_q, cont_d;

    // FIFO storage: instruction word and the address it was fetched from
    logic [7:0] fila_instr_q [PROF_FILA];
    logic [7:0] fila_instr_d [PROF_FILA];
    logic [7:0] fila_pc_q    [PROF_FILA];
    logic [7:0] fila_pc_d    [PROF_FILA];

    logic pop;
    logic push;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    always_comb begin
        instr_valida = (cont_q != 4'd0);
        pop          = instr_valida && instr_pronto;
        // A full FIFO still accepts a fetch when the head leaves this cycle.
        push         = !parar && !desvio_valido && ((cont_q < ProfFila) || pop);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cont_d       = cont_q;
        fila_instr_d = fila_instr_q;
        fila_pc_d    = fila_pc_q;

        if (desvio_valido) begin
            // Redirect wins over push and pop: any same-cycle pop is simply
            // absorbed by the flush. Storage contents are left as they are.
            pc_d     = desvio_alvo;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cont_d   = 4'd0;
        end else begin
            if (push) begin
                fila_instr_d[wr_ptr_q] = mem_instrucao;
                fila_pc_d[wr_ptr_q]    = pc_q;
                // Depth is a power of two, so natural overflow wraps the pointer.
                wr_ptr_d               = wr_ptr_q + PtrW'(1);
                pc_d                   = pc_q + 8'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   cont_d = cont_q + 4'd1;
                2'b01:   cont_d = cont_q - 4'd1;
                default: cont_d = cont_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= PC_INICIAL;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cont_q   <= 4'd0;
            // Storage is cleared so the head fields read zero out of reset.
            for (int i = 0; i < int'(PROF_FILA); i++) begin
                fila_instr_q[i] <= 8'd0;
                fila_pc_q[i]    <= 8'd0;
            end
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cont_q       <= cont_d;
            fila_instr_q <= fila_instr_d;
            fila_pc_q    <= fila_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: head fields come straight from the storage registers. When
    // the FIFO is empty they show whatever the read slot last held.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_endereco = pc_q;
        instr        = fila_instr_q[rd_ptr_q];
        instr_pc     = fila_pc_q[rd_ptr_q];
        ocupacao     = cont_q;
    end

`ifdef CONTADOR_BUSCAS_EN
    // Saturating count of pushes; a redirect does not clear it.
    logic [15:0] num_buscas_q, num_buscas_d;

    always_comb begin
        num_buscas_d = num_buscas_q;
        if (push && (num_buscas_q != 16'hFFFF)) begin
            num_buscas_d = num_buscas_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            num_buscas_q <= 16'd0;
        end else begin
            num_buscas_q <= num_buscas_d;
        end
    end

    assign num_buscas = num_buscas_q;
`endif

endmodule

// File: doc/controle_busca.md
Name: controle_busca

Overview:
- Instruction-fetch controller sequencing `memoria_instrucoes`; sits between that memory and the decoder.
- Owns the program counter and drives the 8-bit memory address.
- Captures the combinational instruction word into a small prefetch FIFO.
- Presents instructions to the decoder over a valid/ready handshake; accepts branch redirects and a halt request.

Parameters:
- PROF_FILA, 2, prefetch FIFO depth in entries; legal values 2, 4, 8.
- PC_INICIAL, 8'd0, PC value loaded on reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_endereco  out  8  address to `memoria_instrucoes`; equals the PC register.
- mem_instrucao  in  8  instruction from `memoria_instrucoes`; combinational from mem_endereco.
- desvio_valido  in  1  redirect request, sampled on the clock edge.
- desvio_alvo  in  8  redirect target address.
- parar  in  1  halt: while high, no new fetches.
- instr_valida  out  1  FIFO head is valid.
- instr  out  8  FIFO head instruction.
- instr_pc  out  8  address the FIFO head was fetched from.
- instr_pronto  in  1  decoder accepts the head (pop when instr_valida && instr_pronto).
- ocupacao  out  4  number of FIFO entries, 0..PROF_FILA.

Behaviour:
- Reset (async assert, sync-free release):
  - pc = PC_INICIAL; FIFO empty.
  - instr_valida = 0; instr = 0; instr_pc = 0; ocupacao = 0.
- mem_endereco = pc at all times; no extra read latency (memory is combinational).
- pop = instr_valida && instr_pronto.
- push = !parar && !desvio_valido && (ocupacao < PROF_FILA || pop).
  - Push and pop in the same cycle are legal, including when the FIFO is full; ocupacao is then unchanged.
- On push:
  - Entry {pc, mem_instrucao} is written at the tail.
  - pc <= pc + 1, modulo 256; 8'd255 wraps to 8'd0 with no flag.
- Redirect (desvio_valido = 1) has priority over push and pop:
  - FIFO flushed (ocupacao <= 0, instr_valida <= 0); pc <= desvio_alvo.
  - A pop handshake in the same cycle is considered consumed; the entry is discarded either way.
  - A redirect while parar = 1 still updates pc and flushes.
- Latency: first instr_valida = 1 one clock edge after the first cycle with push = 1 (reset release or redirect); head fields come straight from the FIFO registers.
- Head outputs:
  - Stable while instr_valida && !instr_pronto, unless a redirect occurs.
  - When the FIFO is empty, instr and instr_pc hold their last values; the bench must not check them when instr_valida = 0.
- Halt: parar = 1 stops push; pc holds; the FIFO keeps draining through pops. Deasserting parar resumes fetching from the held pc.
- FIFO implementation:
  - Circular buffer with read/write pointers of log2(PROF_FILA) bits plus a count register.
  - Pointers wrap at PROF_FILA.
- Full: no push unless a pop occurs the same cycle; pc holds.
- Empty: pop impossible since instr_valida = 0; instr_pronto is ignored.
- Reset mid-operation: all state returns to reset values immediately, independent of clock.

Optional Feature:
- Macro CONTADOR_BUSCAS_EN.
- Defined:
  - Adds output num_buscas out 16: count of pushes since reset.
  - Saturates at 16'hFFFF; not cleared by redirect; resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Memory model: instruction = endereco ^ 8'hA5.
- Sequential fetch: release reset, instr_pronto = 1 constant -> instr_pc = 0,1,2,3 on consecutive cycles; instr = A5,A4,A7,A6; ocupacao stays 1.
- Backpressure: instr_pronto = 0 for 5 cycles with PROF_FILA = 2 -> ocupacao reaches 2; mem_endereco holds at 8'd2; head stays pc 0 / A5; then pronto = 1 -> pcs 0,1,2 delivered in order, none lost.
- Redirect: with FIFO full, pulse desvio_valido, desvio_alvo = 8'd100 -> next cycle ocupacao = 0, instr_valida = 0; the cycle after, head is instr_pc = 100, instr = 8'hC1.
- Wrap-around: redirect to 8'd254 -> delivered pcs 254, 255, 0, 1 with instr 5B, 5A, A5, A4.
- Halt and reset:
  - parar = 1 while full -> FIFO drains to 0 and mem_endereco is frozen; release -> fetch resumes at the frozen pc.
  - Assert reset_n = 0 mid-stream -> outputs zero immediately; with CONTADOR_BUSCAS_EN defined, num_buscas = 0.
